// File: rtl/encrypt.sv
// Symmetric LWE encryption stage: top = m + (e << P) - sum(sk_i * a_i) mod 2^N.
// Define ENCRYPT_NOISE_EN to add the noise term; otherwise the noise port is ignored.
module encrypt #(
  parameter int unsigned DIMENSION = 4,
  parameter int unsigned N         = 30,
  parameter int unsigned P         = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [P-1:0]   message,
  input  logic [N-P-1:0] noise,
  input  logic           coef_valid,
  output logic           coef_ready,
  input  logic [N-1:0]   secret_key_prime,
  input  logic [N-1:0]   rand_coef,
  output logic           bot_valid,
  output logic [N-1:0]   cipher_text_bot,
  output logic           top_valid,
  input  logic           top_ready,
  output logic [N-1:0]   cipher_text_top
);

  localparam int unsigned IDX_W = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIMENSION - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [N-1:0]     acc;
  logic [IDX_W-1:0] idx;

  logic [N-1:0] init_c;
  logic [N-1:0] prod_c;
  logic [N-1:0] acc_sub_c;

  // Accumulator seed: noise sign bits above N-P fall off, so {noise, 0} is the shifted sext.
`ifdef ENCRYPT_NOISE_EN
  assign init_c = {noise, {P{1'b0}}} + N'(message);
`else
  logic unused_noise;
  assign unused_noise = ^noise;
  assign init_c       = N'(message);
`endif

  assign prod_c    = N'(secret_key_prime * rand_coef);
  assign acc_sub_c = acc - prod_c;

  // Control FSM with all handshake outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      acc             <= '0;
      idx             <= '0;
      start_ready     <= 1'b1;
      coef_ready      <= 1'b0;
      bot_valid       <= 1'b0;
      cipher_text_bot <= '0;
      top_valid       <= 1'b0;
      cipher_text_top <= '0;
    end else begin
      bot_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_valid) begin
            acc         <= init_c;
            idx         <= '0;
            start_ready <= 1'b0;
            coef_ready  <= 1'b1;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          if (coef_valid) begin
            acc             <= acc_sub_c;
            cipher_text_bot <= rand_coef;
            bot_valid       <= 1'b1;
            idx             <= idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
              coef_ready      <= 1'b0;
              top_valid       <= 1'b1;
              cipher_text_top <= acc_sub_c;
              state           <= DONE;
            end
          end
        end
        DONE: begin
          if (top_ready) begin
            top_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          start_ready <= 1'b1;
          coef_ready  <= 1'b0;
          top_valid   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
